// File: rtl/line_mem_controller.sv
// Turns one 512-bit cache-line request into a 64-bit-beat bus burst (1 address beat plus 8 data beats).
// It also forwards snoop-invalidate messages from the bus to the arbiter, whatever state the FSM is in.
module line_mem_controller #(
    parameter int          BUS_W     = 64,
    parameter int          LINE_W    = 512,
    parameter logic [15:0] READ_TAG  = 16'h1100,
    parameter logic [15:0] WRITE_TAG = 16'h0100,
    parameter logic [15:0] INVAL_TAG = 16'h0400
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [63:0]       req_addr,
    input  logic              req_wr,
    input  logic [LINE_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [LINE_W-1:0] rsp_rdata,
    output logic              inval_valid,
    output logic [63:0]       inval_addr,
    output logic              bus_reqcyc,
    output logic [BUS_W-1:0]  bus_req,
    output logic [15:0]       bus_reqtag,
    input  logic              bus_reqack,
    input  logic              bus_respcyc,
    input  logic [BUS_W-1:0]  bus_resp,
    input  logic [15:0]       bus_resptag,
    output logic              bus_respack
);
    localparam int            BEATS = LINE_W / BUS_W;
    localparam int            CW    = $clog2(BEATS);
    localparam logic [CW-1:0] LAST  = CW'(BEATS - 1);
    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [63:0]   LINE_MASK = ~64'h3F;

    // Bus handshakes: a request beat moves when bus_reqcyc && bus_reqack are both high in the
    // same cycle, and the beat stays stable until then. Every response beat is acked in the
    // cycle it arrives, so the response side never applies backpressure.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_DATA = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [63:0]       addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              rd_beat;
    logic              snoop;

    assign rd_beat     = (state == RD_DATA) && bus_respcyc && (bus_resptag == READ_TAG);
    assign snoop       = bus_respcyc && (bus_resptag == INVAL_TAG);
    assign bus_respack = bus_respcyc;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        bus_reqcyc = 1'b0;
        bus_req    = '0;
        bus_reqtag = '0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) state_nxt = req_wr ? WR_ADDR : RD_ADDR;
            end
            RD_ADDR: begin
                bus_reqcyc = 1'b1;
                bus_req    = addr_q;
                bus_reqtag = READ_TAG;
                if (bus_reqack) begin
                    cnt_nxt   = '0;
                    state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rd_beat) begin
                    cnt_nxt = cnt + ONE;
                    if (cnt == LAST) state_nxt = DONE;
                end
            end
            WR_ADDR: begin
                bus_reqcyc = 1'b1;
                bus_req    = addr_q;
                bus_reqtag = WRITE_TAG;
                if (bus_reqack) begin
                    cnt_nxt   = '0;
                    state_nxt = WR_DATA;
                end
            end
            WR_DATA: begin
                bus_reqcyc = 1'b1;
                bus_req    = wdata_q[cnt*BUS_W +: BUS_W];
                bus_reqtag = WRITE_TAG;
                if (bus_reqack) begin
                    cnt_nxt = cnt + ONE;
                    if (cnt == LAST) state_nxt = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && req_valid) begin
                addr_q  <= req_addr & LINE_MASK;
                wdata_q <= req_wdata;
            end
        end
    end

    // The read line is updated in place beat by beat. Between reads it holds the last line.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata <= '0;
        end else if (rd_beat) begin
            rsp_rdata[cnt*BUS_W +: BUS_W] <= bus_resp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inval_valid <= 1'b0;
            inval_addr  <= '0;
        end else begin
            inval_valid <= snoop;
            if (snoop) inval_addr <= bus_resp & LINE_MASK;
        end
    end
endmodule

// File: tb/tb_line_mem_controller.sv
// Bench for line_mem_controller: directed and randomized read/write bursts, snoops, stray beats
// and a mid-burst reset, all checked against a transaction-level model of the line and bus beats.
module tb_line_mem_controller;
  localparam logic [15:0] READ_TAG  = 16'h1100;
  localparam logic [15:0] WRITE_TAG = 16'h0100;
  localparam logic [15:0] INVAL_TAG = 16'h0400;
  localparam logic [15:0] STRAY_TAG = 16'h0200;
  localparam logic [63:0] LMASK     = ~64'h3F;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic [63:0]  req_addr;
  logic         req_wr;
  logic [511:0] req_wdata;
  logic         rsp_valid;
  logic [511:0] rsp_rdata;
  logic         inval_valid;
  logic [63:0]  inval_addr;
  logic         bus_reqcyc;
  logic [63:0]  bus_req;
  logic [15:0]  bus_reqtag;
  logic         bus_reqack;
  logic         bus_respcyc;
  logic [63:0]  bus_resp;
  logic [15:0]  bus_resptag;
  logic         bus_respack;

  line_mem_controller dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_wr(req_wr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .inval_valid(inval_valid), .inval_addr(inval_addr),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
    .bus_respack(bus_respack)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // scoreboard state
  logic [511:0] exp_line;
  logic [63:0]  exp_q[$];
  logic [63:0]  rd_beats[8];
  int           gap_n[8];
  int           wr_stall[8];
  int           snoop_at;
  logic [63:0]  snoop_val;
  int           stray_at;
  bit           snoop_en;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // One clock: check the combinational ack, then after the edge check the snoop pulse.
  task automatic tick();
    logic snp;
    logic [63:0] sa;
    #3;
    chk("respack", bus_respack, bus_respcyc);
    snp = bus_respcyc && (bus_resptag == INVAL_TAG) && !rst;
    sa  = bus_resp;
    @(posedge clk);
    #1;
    cyc++;
    chk("inval_valid", inval_valid, snp);
    if (snp) chk("inval_addr", inval_addr, sa & LMASK);
  endtask

  // driver tasks
  task automatic bus_idle();
    bus_reqack  = 1'b0;
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    bus_resptag = '0;
  endtask

  task automatic rand_snoop();
    if (snoop_en && $urandom_range(0, 3) == 0) begin
      bus_respcyc = 1'b1;
      bus_resptag = INVAL_TAG;
      bus_resp    = rnd64();
    end else begin
      bus_respcyc = 1'b0;
    end
  endtask

  task automatic clear_knobs();
    for (int i = 0; i < 8; i++) begin
      gap_n[i]    = 0;
      wr_stall[i] = 0;
      rd_beats[i] = rnd64();
    end
    snoop_at = -1;
    stray_at = -1;
  endtask

  task automatic start_req(input logic wr, input logic [63:0] a, input logic [511:0] wd,
                           input bit from_done, output int t0);
    bus_idle();
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = wd;
    if (from_done) begin
      tick();
      chk("chain_idle_reqcyc", bus_reqcyc, 1'b0);
      chk("chain_idle_rsp", rsp_valid, 1'b0);
    end else begin
      chk("idle_reqcyc", bus_reqcyc, 1'b0);
    end
    t0 = cyc;
    tick();
    req_valid = 1'b0;
    req_wr    = $urandom_range(0, 1);
    req_addr  = rnd64();
    req_wdata = {16{$urandom()}};
  endtask

  task automatic do_read(input logic [63:0] a, input int stall, input int abort_at, input bit from_done);
    int t0;
    int extra;
    int kind;
    start_req(1'b0, a, '0, from_done, t0);
    extra = 0;
    for (int k = 0; k <= stall; k++) begin
      rand_snoop();
      chk("rd_addr_cyc", bus_reqcyc, 1'b1);
      chk("rd_addr", bus_req, a & LMASK);
      chk("rd_addr_tag", bus_reqtag, READ_TAG);
      bus_reqack = (k == stall);
      tick();
    end
    bus_idle();
    for (int i = 0; i < 8; i++) begin
      if (i == abort_at) begin
        bus_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_line = '0;
        chk("abort_reqcyc", bus_reqcyc, 1'b0);
        chk("abort_rsp", rsp_valid, 1'b0);
        chk("abort_rdata", rsp_rdata, exp_line);
        return;
      end
      for (int g = 0; g < gap_n[i]; g++) begin
        kind = $urandom_range(0, 2);
        bus_respcyc = (kind != 0);
        bus_resptag = (kind == 1) ? INVAL_TAG : STRAY_TAG;
        bus_resp    = rnd64();
        tick();
        extra++;
        chk("rd_gap_rsp", rsp_valid, 1'b0);
        chk("rd_gap_line", rsp_rdata, exp_line);
      end
      if (i == snoop_at) begin
        bus_respcyc = 1'b1;
        bus_resptag = INVAL_TAG;
        bus_resp    = snoop_val;
        tick();
        extra++;
        chk("rd_snoop_line", rsp_rdata, exp_line);
      end
      if (i == stray_at) begin
        bus_respcyc = 1'b1;
        bus_resptag = STRAY_TAG;
        bus_resp    = rnd64();
        tick();
        extra++;
        chk("rd_stray_rsp", rsp_valid, 1'b0);
        chk("rd_stray_line", rsp_rdata, exp_line);
      end
      bus_respcyc = 1'b1;
      bus_resptag = READ_TAG;
      bus_resp    = rd_beats[i];
      chk("rd_data_reqcyc", bus_reqcyc, 1'b0);
      chk("rd_data_rsp", rsp_valid, 1'b0);
      tick();
      exp_line[64*i +: 64] = rd_beats[i];
    end
    bus_idle();
    chk("rd_rsp_valid", rsp_valid, 1'b1);
    chk("rd_latency", cyc - t0, 2 + stall + 8 + extra);
    chk("rd_line", rsp_rdata, exp_line);
    chk("rd_done_reqcyc", bus_reqcyc, 1'b0);
  endtask

  task automatic do_write(input logic [63:0] a, input logic [511:0] wd, input int stall,
                          input bit from_done);
    int t0;
    int total;
    start_req(1'b1, a, wd, from_done, t0);
    for (int i = 0; i < 8; i++) exp_q.push_back(wd[64*i +: 64]);
    for (int k = 0; k <= stall; k++) begin
      rand_snoop();
      chk("wr_addr_cyc", bus_reqcyc, 1'b1);
      chk("wr_addr", bus_req, a & LMASK);
      chk("wr_addr_tag", bus_reqtag, WRITE_TAG);
      bus_reqack = (k == stall);
      tick();
    end
    total = 0;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k <= wr_stall[i]; k++) begin
        rand_snoop();
        chk("wr_data_cyc", bus_reqcyc, 1'b1);
        chk("wr_data", bus_req, exp_q[0]);
        chk("wr_data_tag", bus_reqtag, WRITE_TAG);
        chk("wr_data_rsp", rsp_valid, 1'b0);
        bus_reqack = (k == wr_stall[i]);
        tick();
        if (k == wr_stall[i]) void'(exp_q.pop_front());
      end
      total += wr_stall[i] + 1;
    end
    bus_idle();
    chk("wr_rsp_valid", rsp_valid, 1'b1);
    chk("wr_latency", cyc - t0, 2 + stall + total);
    chk("wr_queue_empty", exp_q.size(), 0);
    chk("wr_keeps_line", rsp_rdata, exp_line);
    chk("wr_done_reqcyc", bus_reqcyc, 1'b0);
  endtask

  task automatic idle_cycles(input int n);
    for (int j = 0; j < n; j++) begin
      tick();
      chk("idle_rsp", rsp_valid, 1'b0);
      chk("idle_reqcyc", bus_reqcyc, 1'b0);
      rand_snoop();
    end
    bus_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] wd;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wr = 1'b0; req_wdata = '0;
    snoop_en = 1'b0;
    exp_line = '0;
    bus_idle();
    clear_knobs();
    @(posedge clk);
    #1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_inval_valid", inval_valid, 1'b0);
    chk("rst_reqcyc", bus_reqcyc, 1'b0);
    chk("rst_rdata", rsp_rdata, 512'd0);
    chk("rst_inval_addr", inval_addr, 64'd0);
    tick();

    // read with immediate acks and beats 0..7
    clear_knobs();
    for (int i = 0; i < 8; i++) rd_beats[i] = 64'(i);
    do_read(64'h1234_5678_9ABC_DEF7, 0, 8, 1'b0);
    idle_cycles(2);

    // write with address ack and beat 4 ack each held off for 3 cycles
    clear_knobs();
    for (int i = 0; i < 8; i++) wd[64*i +: 64] = 64'(8'hA0 + i);
    wr_stall[4] = 3;
    do_write(64'h0000_0000_0040_1000, wd, 3, 1'b0);
    idle_cycles(2);

    // snoop injected between read beats 3 and 4
    clear_knobs();
    snoop_at  = 4;
    snoop_val = 64'h8000_003F;
    do_read(rnd64(), 0, 8, 1'b0);
    idle_cycles(2);

    // stray tags inside a read and while idle
    clear_knobs();
    stray_at = 2;
    do_read(rnd64(), 1, 8, 1'b0);
    idle_cycles(1);
    bus_respcyc = 1'b1; bus_resptag = STRAY_TAG; bus_resp = rnd64();
    tick();
    chk("idle_stray_rsp", rsp_valid, 1'b0);
    chk("idle_stray_line", rsp_rdata, exp_line);
    bus_respcyc = 1'b1; bus_resptag = READ_TAG; bus_resp = rnd64();
    tick();
    chk("idle_rdtag_rsp", rsp_valid, 1'b0);
    chk("idle_rdtag_reqcyc", bus_reqcyc, 1'b0);
    chk("idle_rdtag_line", rsp_rdata, exp_line);
    clear_knobs();
    do_read(rnd64(), 0, 8, 1'b0);
    idle_cycles(2);

    // reset after read beat 5, then a fresh read
    clear_knobs();
    do_read(rnd64(), 0, 6, 1'b0);
    idle_cycles(3);
    clear_knobs();
    do_read(rnd64(), 0, 8, 1'b0);
    idle_cycles(1);

    // request held high across DONE: read, write, read back to back
    clear_knobs();
    do_read(rnd64(), 0, 8, 1'b0);
    clear_knobs();
    do_write(rnd64(), {16{$urandom()}}, 1, 1'b1);
    clear_knobs();
    do_read(rnd64(), 0, 8, 1'b1);
    idle_cycles(3);

    // randomized traffic with snoops, gaps and stalls
    snoop_en = 1'b1;
    for (int t = 0; t < 16; t++) begin
      clear_knobs();
      for (int i = 0; i < 8; i++) begin
        gap_n[i]    = $urandom_range(0, 2);
        wr_stall[i] = $urandom_range(0, 2);
      end
      if ($urandom_range(0, 1) == 1) begin
        do_write(rnd64(), {16{$urandom()}}, $urandom_range(0, 3), 1'b0);
      end else begin
        do_read(rnd64(), $urandom_range(0, 3), 8, 1'b0);
      end
      idle_cycles($urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
